counter16_interval_ctrl: RTL and testbench

Controller that sequences a 16-bit up counter as a programmable interval timer for the simple-register benchmarks. It accepts a start command through a valid/ready handshake and runs the counter in one-shot or auto-reload mode. It supports pause and stop, and reports each expiry as a single-cycle pulse plus a saturating expiry tally. It sits between a command source (a test sequencer or CPU-side register block) and any logic that needs periodic or delayed events.

---
 rtl/counter16_interval_ctrl.sv | 178 +++++++++++++++++
 tb/tb_counter16_interval_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter16_interval_ctrl.sv
// counter16_interval_ctrl
//
// Programmable interval timer built around a WIDTH-bit up counter. A start command is
// accepted through a valid/ready handshake and latches the terminal count, the reload mode
// and (optionally) a tick divider. Each expiry produces a one-cycle pulse and bumps a
// saturating tally.
//
// Optional feature macro: COUNTER16_CTRL_PRESCALE_EN adds the prescale port and an 8-bit
// prescaler. Without it the counter ticks on every unpaused RUN cycle.
//
// Ports:
//   clock0        in   sole clock, rising edge
//   resetn        in   asynchronous active-low reset
//   start_valid   in   start command valid
//   start_ready   out  start command can be accepted (IDLE or DONE)
//   start_period  in   terminal count P, sampled on handshake
//   start_reload  in   1 = auto-reload, 0 = one-shot, sampled on handshake
//   prescale      in   tick divider N, sampled on handshake (macro builds only)
//   pause         in   level, freezes counting while high
//   stop          in   level, aborts the run and clears the count
//   count         out  current counter value
//   busy          out  high in RUN or HOLD
//   expire        out  one-cycle pulse on reaching the terminal count
//   expire_cnt    out  expiries since the last accepted start, saturating at 255

module counter16_interval_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock0,
    input  logic             resetn,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_period,
    input  logic             start_reload,
`ifdef COUNTER16_CTRL_PRESCALE_EN
    input  logic [7:0]       prescale,
`endif
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expire,
    output logic [7:0]       expire_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             reload_q, reload_d;
    logic             expire_q, expire_d;
    logic [7:0]       ecnt_q, ecnt_d;
    logic             active;
    logic             presc_term;

`ifdef COUNTER16_CTRL_PRESCALE_EN
    logic [7:0] presc_q, presc_d;
    logic [7:0] presc_n_q, presc_n_d;
    assign presc_term = (presc_q == presc_n_q);
`else
    assign presc_term = 1'b1;
`endif

    assign active = (state_q == StRun) || (state_q == StHold);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        reload_d  = reload_q;
        expire_d  = 1'b0;
        ecnt_d    = ecnt_q;
`ifdef COUNTER16_CTRL_PRESCALE_EN
        presc_d   = presc_q;
        presc_n_d = presc_n_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                // stop outranks a simultaneous start; the tally survives a stop
                if (stop) begin
                    state_d = StIdle;
                    count_d = '0;
`ifdef COUNTER16_CTRL_PRESCALE_EN
                    presc_d = '0;
`endif
                end else if (start_valid) begin
                    state_d   = StRun;
                    count_d   = '0;
                    period_d  = start_period;
                    reload_d  = start_reload;
                    ecnt_d    = '0;
`ifdef COUNTER16_CTRL_PRESCALE_EN
                    presc_d   = '0;
                    presc_n_d = prescale;
`endif
                end
            end
            StRun, StHold: begin
                if (stop) begin
                    state_d = StIdle;
                    count_d = '0;
`ifdef COUNTER16_CTRL_PRESCALE_EN
                    presc_d = '0;
`endif
                end else if (pause) begin
                    state_d = StHold;
                end else begin
                    // Leaving HOLD ticks on the same edge, so a k-cycle pause costs exactly k
                    state_d = StRun;
                    if (presc_term) begin
`ifdef COUNTER16_CTRL_PRESCALE_EN
                        presc_d = '0;
`endif
                        if (count_q == period_q) begin
                            expire_d = 1'b1;
                            if (ecnt_q != 8'hFF) begin
                                ecnt_d = ecnt_q + 8'd1;
                            end
                            if (reload_q) begin
                                count_d = '0;
                            end else begin
                                state_d = StDone;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end else begin
`ifdef COUNTER16_CTRL_PRESCALE_EN
                        presc_d = presc_q + 8'd1;
`endif
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock0 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            count_q   <= '0;
            period_q  <= '0;
            reload_q  <= 1'b0;
            expire_q  <= 1'b0;
            ecnt_q    <= '0;
`ifdef COUNTER16_CTRL_PRESCALE_EN
            presc_q   <= '0;
            presc_n_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            reload_q  <= reload_d;
            expire_q  <= expire_d;
            ecnt_q    <= ecnt_d;
`ifdef COUNTER16_CTRL_PRESCALE_EN
            presc_q   <= presc_d;
            presc_n_q <= presc_n_d;
`endif
        end
    end

    assign start_ready = !active;
    assign busy        = active;
    assign count       = count_q;
    assign expire      = expire_q;
    assign expire_cnt  = ecnt_q;

endmodule

// File: tb/tb_counter16_interval_ctrl.sv
module tb_counter16_interval_ctrl;

    logic        clock0 = 1'b0;
    logic        resetn = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] start_period = '0;
    logic        start_reload = 1'b0;
    logic [7:0]  prescale_v = '0;
    logic        pause = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] count;
    logic        busy;
    logic        expire;
    logic [7:0]  expire_cnt;

    counter16_interval_ctrl #(.WIDTH(16)) dut (
        .clock0      (clock0),
        .resetn      (resetn),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_period(start_period),
        .start_reload(start_reload),
`ifdef COUNTER16_CTRL_PRESCALE_EN
        .prescale    (prescale_v),
`endif
        .pause       (pause),
        .stop        (stop),
        .count       (count),
        .busy        (busy),
        .expire      (expire),
        .expire_cnt  (expire_cnt)
    );

    always #5 clock0 = ~clock0;

    int checks = 0;
    int failures = 0;

    // Reference model: timing is derived from the number of unpaused active edges since start.
    bit m_run;
    bit m_reload;
    bit m_expire;
    int m_p;
    int m_n;
    int m_cyc;
    int m_count;
    int m_ecnt;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_run = 0; m_reload = 0; m_expire = 0;
        m_p = 0; m_n = 0; m_cyc = 0; m_count = 0; m_ecnt = 0;
    endfunction

    function automatic void model_edge();
        longint unit;
        longint per;
        longint tk;
        m_expire = 0;
        if (stop) begin
            m_run = 0;
            m_count = 0;
        end else if (!m_run) begin
            if (start_valid) begin
                m_p = int'(start_period);
                m_reload = start_reload;
`ifdef COUNTER16_CTRL_PRESCALE_EN
                m_n = int'(prescale_v);
`else
                m_n = 0;
`endif
                m_cyc = 0; m_ecnt = 0; m_count = 0; m_run = 1;
            end
        end else if (!pause) begin
            m_cyc++;
            unit = longint'(m_n) + 1;
            per = longint'(m_p) + 1;
            if (m_cyc % unit == 0) begin
                tk = m_cyc / unit;
                if (tk % per == 0) begin
                    m_expire = 1;
                    if (m_ecnt < 255) m_ecnt++;
                    if (m_reload) begin
                        m_count = 0;
                    end else begin
                        m_run = 0;
                        m_count = m_p;
                    end
                end else begin
                    m_count = int'(tk % per);
                end
            end
        end
    endfunction

    task automatic drive(input bit sv, input int p, input bit r, input bit pa, input bit st,
                         input int n);
        start_valid = sv;
        start_period = p[15:0];
        start_reload = r;
        pause = pa;
        stop = st;
        prescale_v = n[7:0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clock0);
        #1;
        check("count", int'(count), m_count);
        check("busy", int'(busy), int'(m_run));
        check("expire", int'(expire), int'(m_expire));
        check("expire_cnt", int'(expire_cnt), m_ecnt);
        check("start_ready", int'(start_ready), int'(!m_run));
    endtask

    typedef struct {
        bit sv;
        int p;
        bit r;
        bit pa;
        bit st;
        int c;
        bit b;
        bit e;
        bit rd;
        int ec;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int first_exp;
        int seen;

        // one-shot P=3, stop/start priority, pause in reload P=2, stop+pause
        tbl[0]  = '{1, 3, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 2, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 3, 1, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 3, 0, 1, 1, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 3, 0, 0, 1, 1};
        tbl[6]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1};
        tbl[7]  = '{1, 5, 0, 0, 1, 0, 0, 0, 1, 1};
        tbl[8]  = '{1, 2, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 2, 1, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
        tbl[14] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};

        model_reset();
        idle();
        #12;
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(start_ready), 1);
        check("rst_expire_cnt", int'(expire_cnt), 0);
        @(negedge clock0);
        resetn = 1'b1;
        @(posedge clock0);
        #1;

        // Asynchronous reset in the middle of an auto-reload run
        drive(1, 10, 1, 0, 0, 0);
        step();
        idle();
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_count", int'(count), 5);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_expire", int'(expire), 0);
        check("arst_expire_cnt", int'(expire_cnt), 0);
        check("arst_ready", int'(start_ready), 1);
        model_reset();
        @(posedge clock0);
        #1;
        resetn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].sv, tbl[i].p, tbl[i].r, tbl[i].pa, tbl[i].st, 0);
            step();
            check($sformatf("vec%0d_count", i), int'(count), tbl[i].c);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].b));
            check($sformatf("vec%0d_expire", i), int'(expire), int'(tbl[i].e));
            check($sformatf("vec%0d_ready", i), int'(start_ready), int'(tbl[i].rd));
            check($sformatf("vec%0d_expire_cnt", i), int'(expire_cnt), tbl[i].ec);
        end

        // P=0 auto-reload: expiry every tick, tally saturates
        drive(1, 0, 1, 0, 0, 0);
        step();
        idle();
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (expire) seen++;
        end
        check("p0_expire_every_cycle", seen, 300);
        check("p0_saturated", int'(expire_cnt), 255);
        drive(0, 0, 0, 0, 1, 0);
        step();

        // Pause of 4 cycles at count=2 with P=5: expiry moves from edge 6 to edge 10
        drive(1, 5, 1, 0, 0, 0);
        step();
        idle();
        first_exp = -1;
        for (int i = 1; i <= 14; i++) begin
            if (i >= 3 && i <= 6) drive(0, 0, 0, 1, 0, 0);
            else idle();
            step();
            if (expire && first_exp < 0) first_exp = i;
        end
        check("pause_delay_expire_edge", first_exp, 10);
        drive(0, 0, 0, 0, 1, 0);
        step();

        // Start requests during a P=20 one-shot run are ignored
        drive(1, 20, 0, 0, 0, 0);
        step();
        first_exp = -1;
        for (int i = 1; i <= 21; i++) begin
            drive(1, 9, 1, 0, 0, 0);
            step();
            if (i <= 20) check("busy_no_ready", int'(start_ready), 0);
            if (expire && first_exp < 0) first_exp = i;
        end
        check("busy_ignore_expire_edge", first_exp, 21);
        check("busy_ignore_count", int'(count), 20);
        drive(0, 0, 0, 0, 1, 0);
        step();

`ifdef COUNTER16_CTRL_PRESCALE_EN
        // N=2, P=1 one-shot: expiry at edge (P+1)(N+1)=6
        drive(1, 1, 0, 0, 0, 2);
        step();
        idle();
        first_exp = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (expire && first_exp < 0) first_exp = i;
        end
        check("presc_expire_edge", first_exp, 6);
        // Same, with one pause cycle mid-prescale: expiry at edge 7
        drive(1, 1, 0, 0, 0, 2);
        step();
        first_exp = -1;
        for (int i = 1; i <= 9; i++) begin
            if (i == 2) drive(0, 0, 0, 1, 0, 0);
            else idle();
            step();
            if (expire && first_exp < 0) first_exp = i;
        end
        check("presc_pause_expire_edge", first_exp, 7);
        drive(0, 0, 0, 0, 1, 0);
        step();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) == 0, int'($urandom_range(0, 6)), $urandom % 2,
                  ($urandom % 8) == 0, ($urandom % 16) == 0, int'($urandom_range(0, 3)));
            step();
        end
        drive(0, 0, 0, 0, 1, 0);
        step();

        // P=0xFFFF auto-reload: first expiry 65536 edges after the handshake, then count=0
        drive(1, 16'hFFFF, 1, 0, 0, 0);
        step();
        idle();
        first_exp = -1;
        for (int i = 1; i <= 65540; i++) begin
            step();
            if (expire && first_exp < 0) begin
                first_exp = i;
                check("pmax_count_after_expire", int'(count), 0);
            end
        end
        check("pmax_expire_edge", first_exp, 65536);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
